spi_flash_ctrl: RTL
===================

// Module: spi_flash_ctrl
// PURPOSE
//  Command sequencer directly upstream of spi_drive: turns user READ / PAGE_PROGRAM / SECTOR_ERASE requests
//  into spi_drive op transactions (WREN, 0x03/0x02/0x20, RDSR busy-poll). Buffers program data in a page FIFO
//  so spi_drive write requests never stall. Forwards read bytes to the user and reports completion/error.
// PARAMETERS
//  P_POLL_MAX  65535  max RDSR polls before timeout error (16-bit counter)
//  P_FIFO_AW   8      write-FIFO address width; depth 2**P_FIFO_AW = 256 (one flash page)
// PORTS
//  clk             in   1   system clock (same as spi_drive i_clk)
//  rst             in   1   reset, asynchronous, active-high
//  i_cmd_valid     in   1   user command valid
//  o_cmd_ready     out  1   high in IDLE only
//  i_cmd_type      in   2   0 READ, 1 PAGE_PROGRAM, 2 SECTOR_ERASE, 3 reserved (-> error)
//  i_cmd_addr      in   24  flash byte address
//  i_cmd_len       in   9   byte count 0..256 (READ/PP; ignored for SE)
//  i_wr_data       in   8   program data into FIFO
//  i_wr_valid      in   1   push strobe
//  o_wr_ready      out  1   FIFO not full
//  o_rd_data       out  8   read byte
//  o_rd_valid      out  1   read byte strobe, no backpressure
//  o_rd_last       out  1   with final read byte
//  o_busy          out  1   high whenever state != IDLE
//  o_done          out  1   1-cycle pulse, command complete
//  o_err           out  1   1-cycle pulse, command rejected or poll timeout
//  o_op_data       out  32  -> spi_drive i_user_op_data {opcode[7:0], addr[23:0]}
//  o_op_type       out  2   -> i_user_op_type (0 cmd only, 1 cmd+addr, 2 cmd+addr+write)
//  o_op_len        out  16  -> i_user_op_len
//  o_op_clk_len    out  16  -> i_user_clk_len
//  o_op_valid      out  1   -> i_user_op_valid
//  i_op_ready      in   1   <- o_user_op_ready
//  o_drv_wr_data   out  8   -> i_user_write_data
//  i_drv_wr_req    in   1   <- o_user_write_req
//  i_drv_rd_data   in   8   <- o_user_read_data
//  i_drv_rd_valid  in   1   <- o_user_read_valid
// BEHAVIOUR
//  Reset: all outputs 0 except o_cmd_ready=1, o_wr_ready=1; FSM->IDLE, FIFO flushed, counters 0. Reset mid-op
//   aborts immediately; no done/err pulse.
//  Accept on i_cmd_valid&o_cmd_ready. Reject (o_err next cycle, back to IDLE, no SPI traffic): type 3;
//   PP with addr[7:0]+len>256. len==0 READ/PP: o_done next cycle, no traffic.
//  Op issue: o_op_* registered, stable while o_op_valid=1; o_op_valid drops the cycle after valid&ready.
//   Op end = first cycle i_op_ready==1 after the cycle following acceptance.
//  Op encodings (N=len): WREN {06,0} t0 len8 clk8; READ {03,addr} t1 len32 clk32+8N;
//   PP {02,addr} t2 len32 clk32+8N; SE {20,addr} t1 len32 clk32; RDSR {05,0} t0 len8 clk16.
//  FSM: IDLE -> READ: RD_ISSUE->RD_WAIT->DONE.
//   PP: FILL (wait fifo_count>=N) ->WREN_ISSUE->WREN_WAIT->MAIN_ISSUE->MAIN_WAIT->POLL_ISSUE->POLL_WAIT->DONE.
//   SE: WREN_ISSUE..MAIN (no FILL)..POLL->DONE. POLL_WAIT: status bit0==1 -> POLL_ISSUE, poll_cnt+1;
//   ==0 -> DONE. poll_cnt==P_POLL_MAX with busy still set -> ERR. DONE/ERR pulse 1 cycle -> IDLE.
//  Read path: in RD_WAIT each i_drv_rd_valid -> o_rd_data/o_rd_valid 1 cycle later; o_rd_last on byte N.
//   In POLL_WAIT rd bytes captured as status, never forwarded. rd_valid in other states ignored.
//  Write path: each i_drv_wr_req pops FIFO; o_drv_wr_data holds popped byte from next cycle.
//   Empty-FIFO pop cannot occur (FILL gate); if it does, o_drv_wr_data holds 0.
//  FIFO: push when i_wr_valid&o_wr_ready at any time; push+pop same cycle -> count unchanged;
//   9-bit count, pointers wrap mod 256. Excess bytes stay for next PP.
//  clk_len arithmetic 16-bit: 32 + {N,3'b0}; max 32+2048 fits.
// STRUCTURE
//  spi_flash_defs.vh: opcodes (06,03,02,20,05), op_type codes, cmd_type codes, state encodings.
//  Sub-module spi_flash_wfifo: 8-bit x 256 sync FIFO, count output; rest flat in spi_flash_ctrl.
// TESTING (bench uses spi_drive model answering miso per scenario)
//  READ addr 0x000100 len 4, miso const 1 -> op {03,000100} t1 len32 clk64; 4 rd_valid of 0xFF, last on 4th, done.
//  PP addr 0x000010 len 16, bytes 0..15 pushed -> WREN clk8, PP clk160, data 0..15 in order, RDSR, done.
//  SE addr 0x001000, status 1,1,0 -> WREN, SE clk32, exactly 3 RDSR ops, then o_done.
//  PP addr 0x0000F8 len 16 -> o_err next cycle, o_op_valid never asserted.
//  P_POLL_MAX=4, status stuck 1 -> o_err after poll limit, back to IDLE, o_cmd_ready=1.
//  rst asserted during PP MAIN_WAIT -> outputs at reset values, FIFO empty, no done/err pulse.

Source files
------------

// File: rtl/spi_flash_ctrl_pkg.sv
// Shared opcodes, op/command encodings, FSM states and the op payload
// for the SPI flash command sequencer.
package spi_flash_ctrl_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned OPLEN_W = 16;

  localparam logic [7:0] OPC_WREN = 8'h06;
  localparam logic [7:0] OPC_READ = 8'h03;
  localparam logic [7:0] OPC_PP   = 8'h02;
  localparam logic [7:0] OPC_SE   = 8'h20;
  localparam logic [7:0] OPC_RDSR = 8'h05;

  localparam logic [1:0] OPT_CMD         = 2'd0;
  localparam logic [1:0] OPT_CMD_ADDR    = 2'd1;
  localparam logic [1:0] OPT_CMD_ADDR_WR = 2'd2;

  localparam logic [1:0] CMD_READ = 2'd0;
  localparam logic [1:0] CMD_PP   = 2'd1;
  localparam logic [1:0] CMD_SE   = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_ISSUE, ST_RD_WAIT, ST_FILL,
    ST_WREN_ISSUE, ST_WREN_WAIT, ST_MAIN_ISSUE, ST_MAIN_WAIT,
    ST_POLL_ISSUE, ST_POLL_WAIT, ST_DONE, ST_ERR
  } state_t;

  typedef struct packed {
    logic [31:0]        data;
    logic [1:0]         kind;
    logic [OPLEN_W-1:0] len;
    logic [OPLEN_W-1:0] clk_len;
  } op_t;

  function automatic op_t make_op(input logic [7:0] opc, input logic [ADDR_W-1:0] addr,
                                  input logic [1:0] kind, input logic [OPLEN_W-1:0] len,
                                  input logic [OPLEN_W-1:0] clk_len);
    op_t o;
    o.data    = {opc, addr};
    o.kind    = kind;
    o.len     = len;
    o.clk_len = clk_len;
    return o;
  endfunction

  // 32 clocks of command+address, then 8 clocks per data byte
  function automatic logic [OPLEN_W-1:0] data_clk_len(input logic [LEN_W-1:0] n);
    return 16'd32 + (16'(n) << 3);
  endfunction

  function automatic logic is_issue(input state_t s);
    return (s == ST_RD_ISSUE) || (s == ST_WREN_ISSUE) ||
           (s == ST_MAIN_ISSUE) || (s == ST_POLL_ISSUE);
  endfunction

endpackage

// File: rtl/spi_flash_wfifo.sv
// Page-sized program-data FIFO; pop data is registered and reads 0 on an empty pop.
module spi_flash_wfifo #(
  parameter int unsigned P_AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    push_data,
  input  logic          push,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic [P_AW:0] count,
  output logic          ready
);

  localparam int unsigned DEPTH = 1 << P_AW;

  logic [7:0]      mem [DEPTH];
  logic [P_AW-1:0] wr_ptr;
  logic [P_AW-1:0] rd_ptr;
  logic [P_AW:0]   count_d;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && ready;
  assign do_pop  = pop && (count != '0);

  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + (P_AW+1)'(1);
      2'b01:   count_d = count - (P_AW+1)'(1);
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + P_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + P_AW'(1);
      if (pop)     pop_data <= do_pop ? mem[rd_ptr] : 8'h00;
      count <= count_d;
      ready <= (count_d != (P_AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/spi_flash_ctrl.sv
// Flash command sequencer: expands READ / PAGE_PROGRAM / SECTOR_ERASE into
// spi_drive op transactions, buffers program data and forwards read bytes.
module spi_flash_ctrl
  import spi_flash_ctrl_pkg::*;
#(
  parameter int unsigned P_POLL_MAX = 65535,
  parameter int unsigned P_FIFO_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_type,
  input  logic [ADDR_W-1:0]  i_cmd_addr,
  input  logic [LEN_W-1:0]   i_cmd_len,
  input  logic [DATA_W-1:0]  i_wr_data,
  input  logic               i_wr_valid,
  output logic               o_wr_ready,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [31:0]        o_op_data,
  output logic [1:0]         o_op_type,
  output logic [OPLEN_W-1:0] o_op_len,
  output logic [OPLEN_W-1:0] o_op_clk_len,
  output logic               o_op_valid,
  input  logic               i_op_ready,
  output logic [DATA_W-1:0]  o_drv_wr_data,
  input  logic               i_drv_wr_req,
  input  logic [DATA_W-1:0]  i_drv_rd_data,
  input  logic               i_drv_rd_valid
);

  state_t              state_q, state_d;
  logic [1:0]          cmd_type_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [LEN_W-1:0]    cmd_len_q;
  logic                wait_first_q;
  logic [15:0]         poll_cnt_q;
  logic [LEN_W-1:0]    rd_cnt_q;
  logic                status_bit_q;
  logic                cmd_ready_q, busy_q, done_q, err_q;
  logic                op_valid_q;
  op_t                 op_q, op_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q, rd_last_q;
  logic [P_FIFO_AW:0]  fifo_count;

  logic                accept, handshake, op_end, poll_busy, poll_retry, fwd, pp_overflow;
  logic [1:0]          sel_type;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;

  spi_flash_wfifo #(.P_AW(P_FIFO_AW)) u_wfifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (i_wr_data),
    .push      (i_wr_valid),
    .pop       (i_drv_wr_req),
    .pop_data  (o_drv_wr_data),
    .count     (fifo_count),
    .ready     (o_wr_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The cycle right after an op handshake is skipped: spi_drive's ready is still stale there.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    accept      = cmd_ready_q && i_cmd_valid;
    handshake   = op_valid_q && i_op_ready;
    op_end      = !wait_first_q && i_op_ready;
    poll_busy   = i_drv_rd_valid ? i_drv_rd_data[0] : status_bit_q;
    poll_retry  = 1'b0;
    fwd         = (state_q == ST_RD_WAIT) && i_drv_rd_valid;
    pp_overflow = (10'(i_cmd_addr[7:0]) + 10'(i_cmd_len)) > 10'd256;
    sel_type    = (state_q == ST_IDLE) ? i_cmd_type : cmd_type_q;
    sel_addr    = (state_q == ST_IDLE) ? i_cmd_addr : cmd_addr_q;
    sel_len     = (state_q == ST_IDLE) ? i_cmd_len  : cmd_len_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (i_cmd_type)
            CMD_READ: state_d = (i_cmd_len == '0) ? ST_DONE : ST_RD_ISSUE;
            CMD_PP: begin
              if (i_cmd_len == '0)  state_d = ST_DONE;
              else if (pp_overflow) state_d = ST_ERR;
              else                  state_d = ST_FILL;
            end
            CMD_SE:  state_d = ST_WREN_ISSUE;
            default: state_d = ST_ERR;
          endcase
        end
      end
      ST_RD_ISSUE:   if (handshake) state_d = ST_RD_WAIT;
      ST_RD_WAIT:    if (op_end) state_d = ST_DONE;
      ST_FILL:       if (fifo_count >= (P_FIFO_AW+1)'(cmd_len_q)) state_d = ST_WREN_ISSUE;
      ST_WREN_ISSUE: if (handshake) state_d = ST_WREN_WAIT;
      ST_WREN_WAIT:  if (op_end) state_d = ST_MAIN_ISSUE;
      ST_MAIN_ISSUE: if (handshake) state_d = ST_MAIN_WAIT;
      ST_MAIN_WAIT:  if (op_end) state_d = ST_POLL_ISSUE;
      ST_POLL_ISSUE: if (handshake) state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (op_end) begin
          if (!poll_busy)                           state_d = ST_DONE;
          else if (poll_cnt_q == 16'(P_POLL_MAX))   state_d = ST_ERR;
          else begin
            state_d    = ST_POLL_ISSUE;
            poll_retry = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_RD_ISSUE:   op_d = make_op(OPC_READ, sel_addr, OPT_CMD_ADDR, 16'd32, data_clk_len(sel_len));
      ST_WREN_ISSUE: op_d = make_op(OPC_WREN, '0, OPT_CMD, 16'd8, 16'd8);
      ST_MAIN_ISSUE: begin
        if (sel_type == CMD_PP)
          op_d = make_op(OPC_PP, sel_addr, OPT_CMD_ADDR_WR, 16'd32, data_clk_len(sel_len));
        else
          op_d = make_op(OPC_SE, sel_addr, OPT_CMD_ADDR, 16'd32, 16'd32);
      end
      ST_POLL_ISSUE: op_d = make_op(OPC_RDSR, '0, OPT_CMD, 16'd8, 16'd16);
      default:       op_d = op_q;
    endcase
  end

  // Registered outputs and per-command bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_type_q   <= '0;
      cmd_addr_q   <= '0;
      cmd_len_q    <= '0;
      wait_first_q <= 1'b0;
      poll_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      status_bit_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      op_valid_q   <= 1'b0;
      op_q         <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      cmd_ready_q  <= (state_d == ST_IDLE);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERR);
      op_valid_q   <= is_issue(state_d);
      op_q         <= op_d;
      wait_first_q <= handshake;
      if (accept) begin
        cmd_type_q <= i_cmd_type;
        cmd_addr_q <= i_cmd_addr;
        cmd_len_q  <= i_cmd_len;
        poll_cnt_q <= '0;
        rd_cnt_q   <= '0;
      end
      if (state_q == ST_POLL_ISSUE)
        status_bit_q <= 1'b0;
      else if ((state_q == ST_POLL_WAIT) && i_drv_rd_valid)
        status_bit_q <= i_drv_rd_data[0];
      if (poll_retry) poll_cnt_q <= poll_cnt_q + 16'd1;
      rd_valid_q <= fwd;
      rd_last_q  <= fwd && (rd_cnt_q == (cmd_len_q - LEN_W'(1)));
      if (fwd) begin
        rd_data_q <= i_drv_rd_data;
        rd_cnt_q  <= rd_cnt_q + LEN_W'(1);
      end
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_op_valid   = op_valid_q;
  assign o_op_data    = op_q.data;
  assign o_op_type    = op_q.kind;
  assign o_op_len     = op_q.len;
  assign o_op_clk_len = op_q.clk_len;
  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_last    = rd_last_q;

endmodule
